fp_arb: RTL
===========

FP_ARB -- requirements
Module: fp_arb

Interface
REQ-001 Parameter PKT_W, default 62, width of one FP-stage input packet.
REQ-002 Parameter CNT_W, default 8, width of the drop counter.
REQ-003 Signal CP, input, 1: single clock; all state updates on the rising edge.
REQ-004 Signal MR_N, input, 1: reset, asynchronous and active-low.
REQ-005 Signals Send_in0 and Send_in1, input, 1 each: requester 0/1 has a valid packet.
REQ-006 Signals PACKET_IN0 and PACKET_IN1, input, PKT_W each: requester 0/1 packet.
REQ-007 Signals Ack_out0 and Ack_out1, output, 1 each: requester 0/1 input buffer is free.
REQ-008 Signal Send_out, output, 1: PACKET_OUT is valid toward the FP stage.
REQ-009 Signal PACKET_OUT, output, PKT_W: granted packet.
REQ-010 Signal Ack_in, input, 1: FP stage accepts PACKET_OUT.
REQ-011 Signal DEL, input, 1: discard the packet currently held in the output register.
REQ-012 Signal DROP_CNT, output, CNT_W: number of packets discarded by DEL.
REQ-013 Signal GNT_SRC, output, 1: source index of the packet in the output register.

Function
REQ-014 A transfer on any port occurs at a CP edge where the port's Send and Ack are both 1.
- Ack is a ready level, not a pulse.
REQ-015 Each requester has a one-entry input buffer, IBUFx.
- Ack_outx = 1 iff IBUFx is empty, or IBUFx is granted in the same cycle.
REQ-016 The output register OREG has two states, EMPTY and FULL.
- Send_out = 1 iff the state is FULL.
REQ-017 OREG loads from the granted IBUF when OREG is EMPTY, or when it is FULL and Ack_in=1 or DEL=1 in the same cycle.
- Back-to-back packets therefore flow at one per cycle.
REQ-018 Arbitration is round-robin.
- If both IBUFs are full, grant the source not granted last; if one is full, grant it.
- The last-grant pointer updates only on an actual OREG load.
REQ-019 Latency from a PACKET_INx transfer to Send_out=1 with that packet is 2 CP edges when the output is uncontested.
REQ-020 DEL=1 while OREG is FULL empties OREG without a transfer and increments DROP_CNT.
- If Ack_in=1 in the same cycle, DEL takes precedence and the packet counts as dropped.
REQ-021 DROP_CNT saturates at 2^CNT_W-1.
REQ-022 DEL while OREG is EMPTY has no effect.
REQ-023 PACKET_OUT and GNT_SRC are held stable while Send_out=1 and neither Ack_in nor DEL is 1.
REQ-024 The block never reorders packets from the same source.
REQ-025 The block never duplicates or loses a packet other than through DEL.

Reset
REQ-026 MR_N=0 immediately clears, without waiting for a CP edge:
- both IBUFs to empty;
- OREG to EMPTY with PACKET_OUT=0;
- GNT_SRC=0, with the pointer favouring source 0 next;
- DROP_CNT=0.
REQ-027 During reset, Send_out=0 and Ack_out0=Ack_out1=0.
- Ack_out rises on the first CP edge after MR_N deasserts.
REQ-028 Reset mid-transfer discards all buffered packets; no partial state survives.

Structure
REQ-029 A shared package fp_pkg holds:
- PKT_W;
- field offsets color[61:59], gen[58:51], dest[50:44], LR2[43:42], BR[41], CPY[40], OPC[39:34], C[33], Z[32], DataL[31:16], DataR[15:0];
- OPC code constants.
REQ-030 One sub-module, fp_arb_ibuf, implements the one-entry input buffer and is instantiated twice.

Verification
REQ-031 Reset release with Send_in0=1 and PACKET_IN0=62'h1 -> Ack_out0=1 on the first edge; Send_out=1 with PACKET_OUT=62'h1 two edges later.
REQ-032 Both sources streaming continuously with Ack_in=1 -> PACKET_OUT alternates source 0,1,0,1 with one packet per cycle; GNT_SRC toggles each cycle.
REQ-033 Ack_in=0 for 5 cycles with both sources sending -> PACKET_OUT stable, both Ack_out fall after their buffers fill, nothing lost; Ack_in=1 then drains all packets in order.
REQ-034 DEL=1 and Ack_in=1 together with OREG FULL -> DROP_CNT 0->1, packet not counted as delivered; 300 DEL pulses -> DROP_CNT=255.
REQ-035 MR_N=0 asserted mid-stream between edges -> Send_out, Ack_out0/1 and DROP_CNT go to 0 immediately; after release the next grant goes to source 0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP-stage packet definitions: width, field layout and opcode codes.
package fp_pkg;

  localparam int unsigned PKT_W = 62;

  // Field positions inside one FP packet
  localparam int unsigned COLOR_LSB = 59;
  localparam int unsigned COLOR_W   = 3;
  localparam int unsigned GEN_LSB   = 51;
  localparam int unsigned GEN_W     = 8;
  localparam int unsigned DEST_LSB  = 44;
  localparam int unsigned DEST_W    = 7;
  localparam int unsigned LR2_LSB   = 42;
  localparam int unsigned LR2_W     = 2;
  localparam int unsigned BR_BIT    = 41;
  localparam int unsigned CPY_BIT   = 40;
  localparam int unsigned OPC_LSB   = 34;
  localparam int unsigned OPC_W     = 6;
  localparam int unsigned C_BIT     = 33;
  localparam int unsigned Z_BIT     = 32;
  localparam int unsigned DATAL_LSB = 16;
  localparam int unsigned DATAL_W   = 16;
  localparam int unsigned DATAR_LSB = 0;
  localparam int unsigned DATAR_W   = 16;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [GEN_W-1:0]   gen;
    logic [DEST_W-1:0]  dest;
    logic [LR2_W-1:0]   lr2;
    logic               br;
    logic               cpy;
    logic [OPC_W-1:0]   opc;
    logic               c;
    logic               z;
    logic [DATAL_W-1:0] data_l;
    logic [DATAR_W-1:0] data_r;
  } fp_pkt_t;

  // Opcode codes carried in the OPC field
  localparam logic [OPC_W-1:0] OPC_NOP = 6'h00;
  localparam logic [OPC_W-1:0] OPC_ADD = 6'h01;
  localparam logic [OPC_W-1:0] OPC_SUB = 6'h02;
  localparam logic [OPC_W-1:0] OPC_MUL = 6'h03;
  localparam logic [OPC_W-1:0] OPC_AND = 6'h04;
  localparam logic [OPC_W-1:0] OPC_OR  = 6'h05;
  localparam logic [OPC_W-1:0] OPC_XOR = 6'h06;
  localparam logic [OPC_W-1:0] OPC_SHL = 6'h07;
  localparam logic [OPC_W-1:0] OPC_SHR = 6'h08;
  localparam logic [OPC_W-1:0] OPC_CMP = 6'h09;
  localparam logic [OPC_W-1:0] OPC_MOV = 6'h0A;

  // Output register occupancy
  typedef enum logic {
    OREG_EMPTY = 1'b0,
    OREG_FULL  = 1'b1
  } oreg_state_e;

endpackage

// File: rtl/fp_arb_if.sv
// Handshake bundle between two requesters, the arbiter and the FP stage.
interface fp_arb_if #(
  parameter int unsigned PKT_W = fp_pkg::PKT_W,
  parameter int unsigned CNT_W = 8
);

  logic             Send_in0;
  logic             Send_in1;
  logic [PKT_W-1:0] PACKET_IN0;
  logic [PKT_W-1:0] PACKET_IN1;
  logic             Ack_out0;
  logic             Ack_out1;
  logic             Send_out;
  logic [PKT_W-1:0] PACKET_OUT;
  logic             Ack_in;
  logic             DEL;
  logic [CNT_W-1:0] DROP_CNT;
  logic             GNT_SRC;

  // Requester/FP-stage side
  modport master (
    output Send_in0, Send_in1, PACKET_IN0, PACKET_IN1, Ack_in, DEL,
    input  Ack_out0, Ack_out1, Send_out, PACKET_OUT, DROP_CNT, GNT_SRC
  );

  // Arbiter side
  modport slave (
    input  Send_in0, Send_in1, PACKET_IN0, PACKET_IN1, Ack_in, DEL,
    output Ack_out0, Ack_out1, Send_out, PACKET_OUT, DROP_CNT, GNT_SRC
  );

endinterface

// File: rtl/fp_arb_ibuf.sv
// One-entry input buffer for a single requester.
module fp_arb_ibuf #(
  parameter int unsigned PKT_W = fp_pkg::PKT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             send,
  input  logic [PKT_W-1:0] pkt_in,
  input  logic             grant,
  output logic             ack_c,
  output logic             full,
  output logic [PKT_W-1:0] pkt
);

  logic ready_q;

  // Hold ack low through reset; it comes up on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // Free when empty, or when the held packet leaves this same cycle
  assign ack_c = ready_q & (~full | grant);

  // Buffer slot: refill has priority because a granted slot may refill in the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      pkt  <= '0;
    end else if (send && ack_c) begin
      full <= 1'b1;
      pkt  <= pkt_in;
    end else if (grant) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_arb.sv
// Two-requester round-robin arbiter feeding one FP stage, with discard counting.
module fp_arb #(
  parameter int unsigned PKT_W = fp_pkg::PKT_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic      CP,
  input  logic      MR_N,
  fp_arb_if.slave   bus
);

  import fp_pkg::*;

  oreg_state_e      state_q, state_d;
  logic             full0, full1;
  logic [PKT_W-1:0] pkt0, pkt1;
  logic             ack0_c, ack1_c;
  logic             sel_c, load_c, drop_c;
  logic             grant0_c, grant1_c;
  logic             last_q;
  logic             gnt_src_q;
  logic [PKT_W-1:0] pkt_out_q;
  logic [CNT_W-1:0] drop_cnt_q;

  fp_arb_ibuf #(.PKT_W(PKT_W)) u_ibuf0 (
    .clk    (CP),
    .rst_n  (MR_N),
    .send   (bus.Send_in0),
    .pkt_in (bus.PACKET_IN0),
    .grant  (grant0_c),
    .ack_c  (ack0_c),
    .full   (full0),
    .pkt    (pkt0)
  );

  fp_arb_ibuf #(.PKT_W(PKT_W)) u_ibuf1 (
    .clk    (CP),
    .rst_n  (MR_N),
    .send   (bus.Send_in1),
    .pkt_in (bus.PACKET_IN1),
    .grant  (grant1_c),
    .ack_c  (ack1_c),
    .full   (full1),
    .pkt    (pkt1)
  );

  // Round-robin pick: alternate when both wait, otherwise take whichever waits
  always_comb begin
    sel_c = 1'b0;
    if (full0 && full1) sel_c = ~last_q;
    else if (full1)     sel_c = 1'b1;
  end

  // Output register state register
  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) state_q <= OREG_EMPTY;
    else       state_q <= state_d;
  end

  // Next state, load and drop decisions; DEL wins over Ack_in
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    drop_c  = 1'b0;
    case (state_q)
      OREG_EMPTY: begin
        if (full0 || full1) begin
          load_c  = 1'b1;
          state_d = OREG_FULL;
        end
      end
      OREG_FULL: begin
        drop_c = bus.DEL;
        if (bus.Ack_in || bus.DEL) begin
          if (full0 || full1) load_c  = 1'b1;
          else                state_d = OREG_EMPTY;
        end
      end
      default: state_d = OREG_EMPTY;
    endcase
  end

  assign grant0_c = load_c & ~sel_c;
  assign grant1_c = load_c &  sel_c;

  // Output payload, source tag and round-robin pointer move only on a load
  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      pkt_out_q <= '0;
      gnt_src_q <= 1'b0;
      last_q    <= 1'b1;
    end else if (load_c) begin
      pkt_out_q <= sel_c ? pkt1 : pkt0;
      gnt_src_q <= sel_c;
      last_q    <= sel_c;
    end
  end

  // Saturating count of packets discarded by DEL
  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N)                      drop_cnt_q <= '0;
    else if (drop_c && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
  end

  assign bus.Send_out   = (state_q == OREG_FULL);
  assign bus.PACKET_OUT = pkt_out_q;
  assign bus.GNT_SRC    = gnt_src_q;
  assign bus.DROP_CNT   = drop_cnt_q;
  assign bus.Ack_out0   = ack0_c;
  assign bus.Ack_out1   = ack1_c;

endmodule
